// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan controller: blank pattern,
// hex font (active-low, bit7 = dp, bits6:0 = g..a) and scan state encoding.
package seg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Glyphs for 0..F with dp off (bit7 = 1)
  localparam logic [7:0] SEG_FONT [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_e;

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble + decimal point to active-low segment pattern.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       dp,
  output logic [7:0] seg_c
);

  // Font entries carry dp off in bit7; clearing it lights the dp
  assign seg_c = SEG_FONT[nib] & {~dp, 7'h7F};

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a multi-digit seven-segment display.
// Each digit slot starts with a blanking guard, then shows the active glyph.
// New contents are staged and applied at the frame wrap (digit DIGITS-1 -> 0).
// Optional build macro SEG_SCAN_LZB_EN enables leading-zero blanking.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS    = 6,
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 500
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  output logic                  upd_ack,
  output logic                  frame_done,
  output logic [2:0]            sel,
  output logic [7:0]            seg
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DW    = 4 * DIGITS;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_SHOW = CNT_W'(BLANK_CYC);
  localparam logic [2:0]       DIG_LAST = 3'(DIGITS - 1);

  scan_state_e        state, nx_state;
  logic [CNT_W-1:0]   cnt, nx_cnt;
  logic [2:0]         dig, nx_dig;
  logic [DW-1:0]      act_data, nx_act_data, pend_data;
  logic [DIGITS-1:0]  act_dp, nx_act_dp, pend_dp;
  logic               pend_vld;
  logic               wrap_c, direct_c, apply_c;
  logic [3:0]         nib_arr [8];
  logic [7:0]         dp_vec;
  logic [3:0]         nib_c;
  logic               dp_c;
  logic [7:0]         pat_c;
  logic               lzb_c;

  // Slot counter / digit index sequencing and state selection
  always_comb begin
    nx_cnt = '0;
    nx_dig = '0;
    if (en && (state != IDLE)) begin
      if (cnt == CNT_LAST) begin
        nx_dig = (dig == DIG_LAST) ? 3'd0 : dig + 3'd1;
      end else begin
        nx_cnt = cnt + CNT_W'(1);
        nx_dig = dig;
      end
    end
    if (!en) begin
      nx_state = IDLE;
    end else if (nx_cnt < CNT_SHOW) begin
      nx_state = BLANK;
    end else begin
      nx_state = SHOW;
    end
  end

  // Update handshake: direct apply when idle or on the wrap edge, else staged
  always_comb begin
    wrap_c      = en && (state != IDLE) && (cnt == CNT_LAST) && (dig == DIG_LAST);
    direct_c    = load && ((state == IDLE) || wrap_c);
    apply_c     = wrap_c && !load && pend_vld;
    nx_act_data = act_data;
    nx_act_dp   = act_dp;
    if (direct_c) begin
      nx_act_data = data_in;
      nx_act_dp   = dp_in;
    end else if (apply_c) begin
      nx_act_data = pend_data;
      nx_act_dp   = pend_dp;
    end
  end

  // Per-digit views of the next active contents, padded to 8 digits
  for (genvar g = 0; g < 8; g++) begin : g_dig
    if (g < DIGITS) begin : g_on
      assign nib_arr[g] = nx_act_data[4*g +: 4];
      assign dp_vec[g]  = nx_act_dp[g];
    end else begin : g_off
      assign nib_arr[g] = 4'h0;
      assign dp_vec[g]  = 1'b0;
    end
  end

  assign nib_c = nib_arr[nx_dig];
  assign dp_c  = dp_vec[nx_dig];

  seg_hex_decode u_dec (
    .nib   (nib_c),
    .dp    (dp_c),
    .seg_c (pat_c)
  );

`ifdef SEG_SCAN_LZB_EN
  // Digit blanks when it and every higher digit is zero and its dp is off
  logic [7:0] nz_vec;
  logic [7:0] lzb_vec;
  for (genvar g = 0; g < 8; g++) begin : g_nz
    assign nz_vec[g] = |nib_arr[g];
  end
  assign lzb_vec[0] = 1'b0;
  for (genvar g = 1; g < 8; g++) begin : g_lzb
    assign lzb_vec[g] = ~|nz_vec[7:g] && !dp_vec[g];
  end
  assign lzb_c = lzb_vec[nx_dig];
`else
  assign lzb_c = 1'b0;
`endif

  // State, contents and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      dig        <= '0;
      act_data   <= '0;
      act_dp     <= '0;
      pend_data  <= '0;
      pend_dp    <= '0;
      pend_vld   <= 1'b0;
      upd_ack    <= 1'b0;
      frame_done <= 1'b0;
      sel        <= 3'd0;
      seg        <= SEG_BLANK;
    end else begin
      state    <= nx_state;
      cnt      <= nx_cnt;
      dig      <= nx_dig;
      act_data <= nx_act_data;
      act_dp   <= nx_act_dp;
      if (load && !direct_c) begin
        pend_data <= data_in;
        pend_dp   <= dp_in;
        pend_vld  <= 1'b1;
      end else if (direct_c || apply_c) begin
        pend_vld  <= 1'b0;
      end
      upd_ack    <= direct_c || apply_c;
      frame_done <= wrap_c;
      sel        <= nx_dig;
      seg        <= ((nx_state == SHOW) && !lzb_c) ? pat_c : SEG_BLANK;
    end
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for the board's 6-digit common-select seven-segment display.
- Shares the single 8-bit segment bus across all digits by cycling the 3-bit digit select.
- Inserts a blanking guard on every digit change to suppress ghosting.
- Accepts new display contents from the application through a frame-synchronous update handshake.

Parameters:
- DIGITS, 6, number of digits scanned (1..8); select values 0..DIGITS-1.
- SCAN_DIV, 50000, clk cycles per digit slot (1 ms at 50 MHz); must be > BLANK_CYC.
- BLANK_CYC, 500, cycles at the start of each slot during which seg is forced blank.

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous reset, active-low
- en  in  1  scan enable; 0 = display dark
- data_in  in  4*DIGITS  hex nibbles; digit i = data_in[4i+3:4i]
- dp_in  in  DIGITS  decimal point per digit, 1 = lit
- load  in  1  single-cycle update request; samples data_in/dp_in
- upd_ack  out  1  1-cycle pulse when the requested contents become active
- frame_done  out  1  1-cycle pulse on every wrap from digit DIGITS-1 to digit 0
- sel  out  3  active digit index
- seg  out  8  active-low segments; bit7 = dp, bits6:0 = g..a

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - sel=0, seg=8'hFF, upd_ack=0, frame_done=0.
  - Active and pending registers cleared; pending flag cleared; slot counter and digit index = 0.
- All outputs are registered; sel and seg always change in the same clock edge.
- States:
  - IDLE: en=0; seg=FF, sel=0.
  - BLANK: slot counter < BLANK_CYC; seg=FF, sel=current digit.
  - SHOW: counter BLANK_CYC..SCAN_DIV-1; seg=font(active nibble) with bit7 = ~dp.
- Transitions:
  - IDLE->BLANK when en=1, starting at digit 0 with counter 0.
  - BLANK->SHOW at counter=BLANK_CYC.
  - SHOW->BLANK at counter=SCAN_DIV-1: digit increments; wraps DIGITS-1 -> 0.
  - Any state->IDLE in the cycle after en falls; counter and digit reset to 0.
- Font, active-low gfedcba: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E.
- Update handshake:
  - load copies data_in/dp_in into pending and sets pending flag; a later load before apply overwrites it (latest wins).
  - Pending is applied to active at the frame boundary, i.e. the edge where the digit wraps to 0; upd_ack pulses in that cycle.
  - load in the boundary cycle: incoming data_in is applied directly, bypassing pending, with upd_ack in the same cycle.
  - In IDLE, load applies on the next edge, with upd_ack in that cycle.
- frame_done pulses in the same cycle as the wrap; it is never asserted in IDLE.
- Slot counter width is clog2(SCAN_DIV); the digit index never reaches DIGITS.

Optional Feature:
- Macro: SEG_SCAN_LZB_EN.
- Defined: leading-zero blanking. Digit i (i>=1) shows FF when its nibble and all higher-index nibbles are 0 and dp_in[i]=0. A set dp keeps that digit's "0" visible. Digit 0 is never blanked.
- Undefined: every digit shows its glyph, and value 0 renders as C0.

Decomposition:
- Package seg_pkg:
  - SEG_BLANK = 8'hFF.
  - 16-entry font constant array.
  - Scan state enum typedef {IDLE, BLANK, SHOW}.
- Sub-module seg_hex_decode: combinational nibble+dp -> 8-bit active-low pattern. Instantiated once on the muxed active nibble.

Test Plan (DIGITS=6, SCAN_DIV=8, BLANK_CYC=2):
- Reset released, en=1, active=0x000000: sel steps 0..5, 8 cycles each; seg=FF for 2 cycles then C0 for 6; frame_done pulses every 48 cycles.
- load with data_in=0x FEDCBA (nibbles 5..0), dp_in=6'b000001 mid-frame: no change until the wrap; upd_ack coincides with frame_done. Slot 0 shows 08 (A with dp), slot 1 shows 83, slot 5 shows 8E.
- Two loads (0x111111 then 0x222222) in one frame: a single upd_ack, and all digits show A4.
- load asserted exactly in the wrap cycle with 0x333333: upd_ack in that cycle, and slot 0 of the new frame shows B0.
- en dropped in SHOW of digit 3: next cycle sel=0, seg=FF. Re-enabling restarts at digit 0 with BLANK.
- rst_n pulsed low mid-SHOW: seg=FF and sel=0 asynchronously, before the next clk edge. With SEG_SCAN_LZB_EN and active=0x000105: digits 5,4,3 show FF; digits 2..0 show F9, C0, 92.
